gate_identifier: RTL and testbench
==================================

Name: gate_identifier

Overview:
- Inverse of the 4-bit bitwise gate bank. It observes (a, b, y) sample triples and decides which of the five two-input functions produced y: AND, OR, XOR, NAND or NOR.
- Each accepted sample narrows a registered candidate set until one of three results is reached: exactly one function remains (found), none remains (fail), or the sample budget runs out (ambiguous).
- Used as a self-check and classification block beside the gate-level datapath.

Parameters:
- WIDTH, 4, bit width of a, b and y.
- MAX_SAMPLES, 8, number of accepted samples after which a still-multiple candidate set is declared ambiguous (must be 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins or restarts an identification run.
- valid  input  1  a, b and y carry a sample this cycle.
- a  input  WIDTH  sample operand A.
- b  input  WIDTH  sample operand B.
- y  input  WIDTH  observed output for this sample.
- busy  output  1  high while in ACCUM; samples are accepted only then.
- done  output  1  high in FOUND, FAIL or AMBIG.
- status  output  2  00 none/running, 01 found, 10 fail, 11 ambiguous.
- cand  output  5  candidate mask: bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR.
- gate_code  output  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 7 none or ambiguous.
- count  output  4  number of samples accepted in the current run.

Behaviour:
- One clock; reset is synchronous and active-high. On reset: state IDLE, cand=5'b11111, count=0, busy=0, done=0, status=00, gate_code=3'b111.
- All outputs are registered, or decoded only from registered state.
- Match vector per sample, using full-width equality:
  - m[0] = (y == a&b)
  - m[1] = (y == a|b)
  - m[2] = (y == a^b)
  - m[3] = (y == ~(a&b))
  - m[4] = (y == ~(a|b))
- States:
  - IDLE -> ACCUM on start. Loads cand=11111 and count=0.
  - ACCUM with valid: next = cand & m; count increments by 1.
    - next == 0 -> FAIL.
    - next one-hot -> FOUND.
    - count+1 == MAX_SAMPLES -> AMBIG.
    - Otherwise stay in ACCUM.
    - These conditions are evaluated in that priority order.
  - ACCUM without valid: hold all state.
  - FOUND, FAIL and AMBIG are terminal. They hold until start (-> ACCUM, re-initialised) or reset.
- Latency: a sample presented with valid at edge N updates cand, count and state at edge N. done and status are visible from edge N onward, i.e. one cycle after the sample is presented.
- start takes priority over valid in every state. A sample presented in the same cycle as start is dropped, and the run restarts with cand=11111 and count=0.
- valid outside ACCUM is ignored, with no state change.
- Reset mid-run: abandons the run and returns to reset values. No partial result is retained.
- gate_code = index of the single set bit of cand in FOUND; 3'b111 in every other state.
- status: 01 in FOUND, 10 in FAIL, 11 in AMBIG, 00 in IDLE and ACCUM.
- count saturates at MAX_SAMPLES and never wraps, since AMBIG is entered at that point.
- cand is never re-widened during a run; it only loses bits.

Test Plan:
- Single-sample hit: reset, start, then valid a=0011 b=0101 y=0110 -> next cycle: FOUND, cand=00100, gate_code=2, count=1, status=01, busy=0.
- Two-sample hit: start; a=b=1111 y=1111 -> ACCUM with cand=00011; then a=1111 b=0000 y=0000 -> FOUND, cand=00001, gate_code=0, count=2.
- Fail: start; a=0011 b=0101 y=1111 -> FAIL, cand=00000, status=10, gate_code=7.
- Ambiguous: start; 8 samples a=b=0000 y=0000 -> after the 8th, AMBIG with cand=00111, count=8, status=11, gate_code=7. Check the state is still ACCUM after the 7th.
- Restart and ignore rules:
  - valid while IDLE or FOUND -> no change.
  - start asserted together with a valid hit sample while in ACCUM with cand=00011 -> ACCUM, cand=11111, count=0; the sample is dropped.
- Reset mid-run: in ACCUM with count=3, assert reset for one cycle -> IDLE, cand=11111, count=0, done=0. A following start and a=0011 b=0101 y=1000 -> FOUND, gate_code=4.

Source files
------------

// File: rtl/gate_identifier.sv
// gate_identifier: watches (a, b, y) sample triples and works out which
// two-input bitwise function (AND, OR, XOR, NAND, NOR) produced y. Each
// accepted sample removes the functions it rules out from a registered
// candidate set. A run ends when exactly one function is left (found), none
// is left (fail), or the sample budget runs out (ambiguous).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      single-cycle pulse; begins or restarts a run (wins over valid)
//   valid      a/b/y carry a sample this cycle (used only while busy)
//   a, b       sample operands
//   y          observed output for the sample
//   busy       high while samples are accepted
//   done       high once the run has reached found, fail or ambiguous
//   status     00 none/running, 01 found, 10 fail, 11 ambiguous
//   cand       candidate mask: bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR
//   gate_code  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 7 none or ambiguous
//   count      number of samples accepted in the current run
module gate_identifier #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [4:0]       cand,
  output logic [2:0]       gate_code,
  output logic [3:0]       count
);

  localparam int unsigned NGATE = 5;
  localparam int unsigned CW    = 4;
  localparam int unsigned SW    = 2;
  localparam int unsigned GW    = 3;

  localparam logic [SW-1:0] STATUS_NONE  = 2'b00;
  localparam logic [SW-1:0] STATUS_FOUND = 2'b01;
  localparam logic [SW-1:0] STATUS_FAIL  = 2'b10;
  localparam logic [SW-1:0] STATUS_AMBIG = 2'b11;
  localparam logic [GW-1:0] CODE_NONE    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_FOUND = 3'd2,
    S_FAIL  = 3'd3,
    S_AMBIG = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [NGATE-1:0]  cand_next;
  logic [CW-1:0]     count_next;
  logic              busy_next;
  logic              done_next;
  logic [SW-1:0]     status_next;
  logic [GW-1:0]     gate_code_next;

  logic [NGATE-1:0]  match_c;
  logic [NGATE-1:0]  narrowed_c;
  logic              narrowed_onehot_c;
  logic [CW-1:0]     count_inc_c;

  // Index of the lowest set bit; only meaningful when v is one-hot.
  function automatic logic [GW-1:0] onehot_index(input logic [NGATE-1:0] v);
    logic [GW-1:0] idx;
    idx = CODE_NONE;
    for (int i = NGATE - 1; i >= 0; i--) begin
      if (v[i]) idx = GW'(i);
    end
    return idx;
  endfunction

  // Full-width comparison of y against every candidate function.
  always_comb begin
    match_c    = '0;
    match_c[0] = (y == (a & b));
    match_c[1] = (y == (a | b));
    match_c[2] = (y == (a ^ b));
    match_c[3] = (y == ~(a & b));
    match_c[4] = (y == ~(a | b));
  end

  // Candidate set after this sample, and whether exactly one bit survives.
  always_comb begin
    narrowed_c        = cand & match_c;
    narrowed_onehot_c = (narrowed_c != '0) &&
                        ((narrowed_c & (narrowed_c - NGATE'(1))) == '0);
    count_inc_c       = count + CW'(1);
  end

  // Next-state, candidate/count update and next output values.
  always_comb begin
    state_next     = state;
    cand_next      = cand;
    count_next     = count;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    status_next    = STATUS_NONE;
    gate_code_next = CODE_NONE;

    if (start) begin
      // Restart from any state; a sample in the same cycle is dropped.
      state_next = S_ACCUM;
      cand_next  = '1;
      count_next = '0;
    end else if (state == S_ACCUM && valid) begin
      cand_next  = narrowed_c;
      count_next = count_inc_c;
      if (narrowed_c == '0) begin
        state_next = S_FAIL;
      end else if (narrowed_onehot_c) begin
        state_next = S_FOUND;
      end else if (count_inc_c == CW'(MAX_SAMPLES)) begin
        state_next = S_AMBIG;
      end
    end

    case (state_next)
      S_ACCUM: busy_next = 1'b1;
      S_FOUND: begin
        done_next      = 1'b1;
        status_next    = STATUS_FOUND;
        gate_code_next = onehot_index(cand_next);
      end
      S_FAIL: begin
        done_next   = 1'b1;
        status_next = STATUS_FAIL;
      end
      S_AMBIG: begin
        done_next   = 1'b1;
        status_next = STATUS_AMBIG;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cand      <= '1;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= STATUS_NONE;
      gate_code <= CODE_NONE;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      count     <= count_next;
      busy      <= busy_next;
      done      <= done_next;
      status    <= status_next;
      gate_code <= gate_code_next;
    end
  end

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: drives hand-built sample triples and
// compares every output against hand-computed values after each edge.
module tb_gate_identifier;

  logic       clk;
  logic       reset;
  logic       start;
  logic       valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [4:0] cand;
  logic [2:0] gate_code;
  logic [3:0] count;

  int tests;
  int fails;

  gate_identifier #(.WIDTH(4), .MAX_SAMPLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valid     (valid),
    .a         (a),
    .b         (b),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .cand      (cand),
    .gate_code (gate_code),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample outputs #1 after the edge.
  task automatic step(input logic st, input logic v, input logic [3:0] ta,
                      input logic [3:0] tb, input logic [3:0] ty);
    start = st;
    valid = v;
    a     = ta;
    b     = tb;
    y     = ty;
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ed,
                           input logic [1:0] es, input logic [4:0] ec,
                           input logic [2:0] eg, input logic [3:0] en);
    check({tag, ".busy"},      32'(busy),      32'(eb));
    check({tag, ".done"},      32'(done),      32'(ed));
    check({tag, ".status"},    32'(status),    32'(es));
    check({tag, ".cand"},      32'(cand),      32'(ec));
    check({tag, ".gate_code"}, 32'(gate_code), 32'(eg));
    check({tag, ".count"},     32'(count),     32'(en));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    a = '0;
    b = '0;
    y = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 1'b0, 1'b0, 2'b00, 5'b11111, 3'd7, 4'd0);

    // valid while IDLE is ignored
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b0110);
    check_all("idle_valid", 1'b0, 1'b0, 2'b00, 5'b11111, 3'd7, 4'd0);

    // single-sample hit: XOR
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    check_all("start1", 1'b1, 1'b0, 2'b00, 5'b11111, 3'd7, 4'd0);
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b0110);
    check_all("xor_found", 1'b0, 1'b1, 2'b01, 5'b00100, 3'd2, 4'd1);

    // valid while FOUND is ignored (would otherwise fail)
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1111);
    check_all("found_valid", 1'b0, 1'b1, 2'b01, 5'b00100, 3'd2, 4'd1);

    // two-sample hit: AND, with an idle cycle in between
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111);
    check_all("and_s1", 1'b1, 1'b0, 2'b00, 5'b00011, 3'd7, 4'd1);
    step(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111);
    check_all("and_hold", 1'b1, 1'b0, 2'b00, 5'b00011, 3'd7, 4'd1);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    check_all("and_found", 1'b0, 1'b1, 2'b01, 5'b00001, 3'd0, 4'd2);

    // fail: no function gives 1111 from 0011/0101
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1111);
    check_all("fail", 1'b0, 1'b1, 2'b10, 5'b00000, 3'd7, 4'd1);

    // ambiguous: zeros never separate AND/OR/XOR
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    check_all("ambig_7", 1'b1, 1'b0, 2'b00, 5'b00111, 3'd7, 4'd7);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    check_all("ambig_8", 1'b0, 1'b1, 2'b11, 5'b00111, 3'd7, 4'd8);

    // start together with a hit sample: sample dropped, run re-initialised
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111);
    check_all("restart_pre", 1'b1, 1'b0, 2'b00, 5'b00011, 3'd7, 4'd1);
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    check_all("restart_drop", 1'b1, 1'b0, 2'b00, 5'b11111, 3'd7, 4'd0);

    // reset mid-run after three samples
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    check_all("pre_reset", 1'b1, 1'b0, 2'b00, 5'b00111, 3'd7, 4'd3);
    reset = 1'b1;
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    check_all("mid_reset", 1'b0, 1'b0, 2'b00, 5'b11111, 3'd7, 4'd0);

    // NOR after reset
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1000);
    check_all("nor_found", 1'b0, 1'b1, 2'b01, 5'b10000, 3'd4, 4'd1);

    // NAND: 0011 nand 0101 = 1110
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1110);
    check_all("nand_found", 1'b0, 1'b1, 2'b01, 5'b01000, 3'd3, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
